// File: rtl/cladapt_pkg.sv
// Shared types and geometry for the cache-line to memory-burst adaptor.
// Contents: FSM state enum, line/beat widths, beat count, line offset bits.
// Imported by cacheline_adaptor.
package cladapt_pkg;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int BEATS       = LINE_W / BURST_W;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = $clog2(BEATS);
    localparam int ADDR_W      = 32;
    localparam int LADDR_W     = ADDR_W - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } cladapt_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Purpose : converts one 256-bit line read/write into a 4-beat 64-bit memory burst.
// Latency : BEATS + 2 cycles minimum from request to line_resp_o (IDLE sample, beats, DONE).
// Backpressure: each beat waits for mem_resp_i; gaps hold the beat counter.
//
// Ports:
//   clk, rst (async, active-low)
//   line_*   : arbiter side - request held until the single-cycle line_resp_o
//   mem_*    : burst side   - mem_read_o/mem_write_o held for the whole burst,
//              one beat accepted per cycle with mem_resp_i high
//   err_o    : sticky watchdog flag
// Build option CLADAPT_TIMEOUT_EN adds a per-beat watchdog (parameter TIMEOUT) that
// sets err_o and forces completion; without it err_o is tied low.
module cacheline_adaptor
    import cladapt_pkg::*;
#(
    parameter int TIMEOUT = 1024
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   line_addr_i,
    input  logic [LINE_W-1:0]   line_wdata_i,
    input  logic                line_read_i,
    input  logic                line_write_i,
    output logic [LINE_W-1:0]   line_rdata_o,
    output logic                line_resp_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic [BURST_W-1:0]  mem_wdata_o,
    input  logic [BURST_W-1:0]  mem_rdata_i,
    input  logic                mem_resp_i,
    output logic                err_o
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    cladapt_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LADDR_W-1:0]  addr_q, addr_d;
    // Holds the write line during WR and assembles read beats during RD.
    logic [LINE_W-1:0]   line_buf_q, line_buf_d;
    // Separate output copy so line_rdata_o stays put until the next read completes.
    logic [LINE_W-1:0]   line_rdata_q, line_rdata_d;

    // Line offset bits are dropped: bursts are always line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^line_addr_i[OFFSET_BITS-1:0];

`ifdef CLADAPT_TIMEOUT_EN
    localparam int               WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        line_buf_d   = line_buf_q;
        line_rdata_d = line_rdata_q;
        line_resp_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                // Write has priority if both strobes are (illegally) high.
                if (line_write_i) begin
                    addr_d     = line_addr_i[ADDR_W-1:OFFSET_BITS];
                    line_buf_d = line_wdata_i;
                    cnt_d      = '0;
                    state_d    = WR;
                end else if (line_read_i) begin
                    addr_d  = line_addr_i[ADDR_W-1:OFFSET_BITS];
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                mem_read_o = 1'b1;
                if (mem_resp_i) begin
                    line_buf_d[BURST_W*cnt_q +: BURST_W] = mem_rdata_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                mem_write_o = 1'b1;
                mem_wdata_o = line_buf_q[BURST_W*cnt_q +: BURST_W];
                if (mem_resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                line_resp_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CLADAPT_TIMEOUT_EN
        // Watchdog counts consecutive silent cycles within a burst; it is
        // cleared by any beat and whenever the FSM is outside RD/WR.
        wdog_d = '0;
        err_d  = err_q;
        if ((state_q == RD || state_q == WR) && !mem_resp_i) begin
            if (wdog_q == WDOG_LAST) begin
                err_d   = 1'b1;
                state_d = DONE;
                cnt_d   = '0;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif

        // Publish the assembled (or, on timeout, partial) line as the read completes.
        if (state_q == RD && state_d == DONE) begin
            line_rdata_d = line_buf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            line_buf_q   <= '0;
            line_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            line_buf_q   <= line_buf_d;
            line_rdata_q <= line_rdata_d;
        end
    end

`ifdef CLADAPT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign line_rdata_o = line_rdata_q;
    assign mem_addr_o   = {addr_q, {OFFSET_BITS{1'b0}}};

    // Simultaneous read and write requests are outside the requester contract.
    always_ff @(posedge clk) begin
        if (rst && state_q == IDLE) begin
            assert (!(line_read_i && line_write_i));
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed and randomized line
// transactions against a transaction-level model (expected beats, latency from
// gap counts, assembled line), plus reset-mid-burst and optional watchdog checks.
module tb_cacheline_adaptor;

    localparam int TB_TIMEOUT = 16;

    logic         clk;
    logic         rst;
    logic [31:0]  line_addr_i;
    logic [255:0] line_wdata_i;
    logic         line_read_i;
    logic         line_write_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  mem_addr_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;
    logic         err_o;

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] last_rd = '0;

    cacheline_adaptor #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_addr_i  (line_addr_i),
        .line_wdata_i (line_wdata_i),
        .line_read_i  (line_read_i),
        .line_write_i (line_write_i),
        .line_rdata_o (line_rdata_o),
        .line_resp_o  (line_resp_o),
        .mem_addr_o   (mem_addr_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_resp_i   (mem_resp_i),
        .err_o        (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Idle cycles; stray mem_resp_i pulses must be ignored outside a burst.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_resp_i  = 1'($urandom_range(0, 1));
            mem_rdata_i = {$urandom, $urandom};
            @(negedge clk);
            n_vec++;
            if (line_resp_o !== 1'b0) begin
                n_err++;
                $error("FAIL idle_resp observed=%0h expected=0", line_resp_o);
            end
            n_vec++;
            if ((mem_read_o | mem_write_o) !== 1'b0) begin
                n_err++;
                $error("FAIL idle_strobe observed=%0h expected=0", mem_read_o | mem_write_o);
            end
        end
        mem_resp_i = 1'b0;
    endtask

    // One line transaction, called at a negedge. after_done: the previous
    // transaction ended at this negedge, so the DUT passes through IDLE first.
    // gmode < 0: random gaps 0..2 before each beat; otherwise no gap before
    // beat 0 and gmode gap cycles before every later beat.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                       input int gmode, input bit fixed_beats, input bit after_done);
        logic [63:0]  beat [4];
        int           gap [4];
        int           lat;
        int           lat_exp;
        int           start_exp;
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        logic [1:0]   strb_exp;
        logic [1:0]   strb_obs;

        exp_addr  = addr & 32'hFFFF_FFE0;
        strb_exp  = {!wr, wr};
        start_exp = after_done ? 2 : 1;
        lat_exp   = start_exp;
        for (int i = 0; i < 4; i++) begin
            beat[i] = fixed_beats ? {16{4'(i + 1)}} : {$urandom, $urandom};
            gap[i]  = (gmode < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gmode);
            // lat_exp counts edges from request drive to the DONE cycle.
            lat_exp += gap[i] + ((i == 0) ? 0 : 1);
            exp_line[64*i +: 64] = beat[i];
        end
        lat_exp += 1;

        line_addr_i  = addr;
        line_wdata_i = wline;
        line_write_i = wr;
        line_read_i  = !wr;
        mem_resp_i   = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(mem_read_o || mem_write_o) && lat < 4);
        n_vec++;
        if (lat !== start_exp) begin
            n_err++;
            $error("FAIL start_lat observed=%0d expected=%0d", lat, start_exp);
        end

        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap[b]; g++) begin
                strb_obs = {mem_read_o, mem_write_o};
                n_vec++;
                if (strb_obs !== strb_exp) begin
                    n_err++;
                    $error("FAIL gap_strobe observed=%0h expected=%0h", strb_obs, strb_exp);
                end
                n_vec++;
                if (mem_addr_o !== exp_addr) begin
                    n_err++;
                    $error("FAIL gap_addr observed=%0h expected=%0h", mem_addr_o, exp_addr);
                end
                n_vec++;
                if (line_resp_o !== 1'b0) begin
                    n_err++;
                    $error("FAIL gap_resp observed=%0h expected=0", line_resp_o);
                end
                mem_resp_i  = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
                @(negedge clk);
                lat++;
            end
            strb_obs = {mem_read_o, mem_write_o};
            n_vec++;
            if (strb_obs !== strb_exp) begin
                n_err++;
                $error("FAIL beat_strobe observed=%0h expected=%0h", strb_obs, strb_exp);
            end
            n_vec++;
            if (mem_addr_o !== exp_addr) begin
                n_err++;
                $error("FAIL beat_addr observed=%0h expected=%0h", mem_addr_o, exp_addr);
            end
            n_vec++;
            if (line_resp_o !== 1'b0) begin
                n_err++;
                $error("FAIL beat_resp observed=%0h expected=0", line_resp_o);
            end
            if (wr) begin
                n_vec++;
                if (mem_wdata_o !== wline[64*b +: 64]) begin
                    n_err++;
                    $error("FAIL wdata observed=%0h expected=%0h", mem_wdata_o, wline[64*b +: 64]);
                end
            end
            mem_resp_i  = 1'b1;
            mem_rdata_i = wr ? {$urandom, $urandom} : beat[b];
            @(negedge clk);
            lat++;
        end
        mem_resp_i = 1'b0;
        while (!line_resp_o && lat < lat_exp + 4) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (line_resp_o !== 1'b1) begin
            n_err++;
            $error("FAIL resp observed=%0h expected=1", line_resp_o);
        end
        n_vec++;
        if (lat !== lat_exp) begin
            n_err++;
            $error("FAIL latency observed=%0d expected=%0d", lat, lat_exp);
        end
        n_vec++;
        if ((mem_read_o | mem_write_o) !== 1'b0) begin
            n_err++;
            $error("FAIL done_strobe observed=%0h expected=0", mem_read_o | mem_write_o);
        end
        if (!wr) last_rd = exp_line;
        n_vec++;
        if (line_rdata_o !== last_rd) begin
            n_err++;
            $error("FAIL rdata observed=%0h expected=%0h", line_rdata_o, last_rd);
        end
        // Requester drops its request in the cycle after line_resp_o.
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l;
        bit           b2b;
        int           lat;

        rst          = 1'b0;
        line_addr_i  = '0;
        line_wdata_i = '0;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        mem_rdata_i  = '0;
        mem_resp_i   = 1'b0;
        #1;
        n_vec++;
        if (line_rdata_o !== 256'h0) begin
            n_err++;
            $error("FAIL rst_rdata observed=%0h", line_rdata_o);
        end
        n_vec++;
        if (line_resp_o !== 1'b0) begin
            n_err++;
            $error("FAIL rst_resp observed=%0h", line_resp_o);
        end
        n_vec++;
        if (mem_addr_o !== 32'h0) begin
            n_err++;
            $error("FAIL rst_addr observed=%0h", mem_addr_o);
        end
        n_vec++;
        if (mem_read_o !== 1'b0) begin
            n_err++;
            $error("FAIL rst_read observed=%0h", mem_read_o);
        end
        n_vec++;
        if (mem_write_o !== 1'b0) begin
            n_err++;
            $error("FAIL rst_write observed=%0h", mem_write_o);
        end
        n_vec++;
        if (mem_wdata_o !== 64'h0) begin
            n_err++;
            $error("FAIL rst_wdata observed=%0h", mem_wdata_o);
        end
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $error("FAIL rst_err observed=%0h", err_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Directed read, consecutive beats 0x1111.., 0x2222.., 0x3333.., 0x4444..
        txn(1'b0, 32'h0000_1234, '0, 0, 1'b1, 1'b0);
        n_vec++;
        if (line_rdata_o !== {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}) begin
            n_err++;
            $error("FAIL dir_rd_line observed=%0h", line_rdata_o);
        end
        idle(2);

        // Directed write; read line must hold across it.
        txn(1'b1, 32'hDEAD_BEEF, rand_line(), 0, 1'b0, 1'b0);
        idle(1);

        // Three wait states between read beats.
        txn(1'b0, 32'h8000_0040, '0, 3, 1'b0, 1'b0);
        idle(1);

        // Back-to-back write then read.
        txn(1'b1, 32'h0000_0100, rand_line(), -1, 1'b0, 1'b0);
        txn(1'b0, 32'h0000_0200, '0, -1, 1'b0, 1'b1);
        idle(1);

        // Reset during a read after two beats have been accepted.
        line_addr_i = 32'h0000_5A5F;
        line_read_i = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            mem_resp_i  = 1'b1;
            mem_rdata_i = {$urandom, $urandom};
            @(negedge clk);
        end
        mem_resp_i  = 1'b0;
        line_read_i = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++;
        if (line_rdata_o !== 256'h0) begin
            n_err++;
            $error("FAIL mid_rst_rdata observed=%0h", line_rdata_o);
        end
        n_vec++;
        if (line_resp_o !== 1'b0) begin
            n_err++;
            $error("FAIL mid_rst_resp observed=%0h", line_resp_o);
        end
        n_vec++;
        if (mem_addr_o !== 32'h0) begin
            n_err++;
            $error("FAIL mid_rst_addr observed=%0h", mem_addr_o);
        end
        n_vec++;
        if (mem_read_o !== 1'b0) begin
            n_err++;
            $error("FAIL mid_rst_read observed=%0h", mem_read_o);
        end
        n_vec++;
        if (mem_wdata_o !== 64'h0) begin
            n_err++;
            $error("FAIL mid_rst_wdata observed=%0h", mem_wdata_o);
        end
        last_rd = '0;
        @(negedge clk);
        n_vec++;
        if (line_resp_o !== 1'b0) begin
            n_err++;
            $error("FAIL mid_rst_hold observed=%0h", line_resp_o);
        end
        rst = 1'b1;
        idle(2);
        txn(1'b0, 32'h0000_5A5F, '0, -1, 1'b0, 1'b0);

        // Randomized mix of reads and writes, random gaps, random back-to-back.
        b2b = 1'b1;
        for (int t = 0; t < 24; t++) begin
            l = rand_line();
            txn(1'($urandom_range(0, 1)), $urandom, l, -1, 1'b0, b2b);
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

`ifdef CLADAPT_TIMEOUT_EN
        // No beats at all: watchdog forces completion after TB_TIMEOUT silent cycles.
        line_addr_i = 32'h0000_0F00;
        line_read_i = 1'b1;
        mem_resp_i  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!line_resp_o && lat < TB_TIMEOUT + 10);
        n_vec++;
        if (line_resp_o !== 1'b1) begin
            n_err++;
            $error("FAIL to_resp observed=%0h", line_resp_o);
        end
        n_vec++;
        if (lat !== TB_TIMEOUT + 1) begin
            n_err++;
            $error("FAIL to_latency observed=%0d expected=%0d", lat, TB_TIMEOUT + 1);
        end
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $error("FAIL to_err observed=%0h", err_o);
        end
        line_read_i = 1'b0;
        idle(3);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $error("FAIL to_err_sticky observed=%0h", err_o);
        end
`else
        lat = 0;
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $error("FAIL err_tied observed=%0h", err_o);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
